// File: rtl/alu_share_pkg.sv
// alu_share_pkg: opcodes, FSM states and constants shared by the ALU-sharing controller.
package alu_share_pkg;
   localparam logic [2:0] OP_ADD  = 3'b000;
   localparam logic [2:0] OP_SUB  = 3'b001;
   localparam logic [2:0] OP_MUL  = 3'b010;
   localparam logic [2:0] OP_DIV  = 3'b011;
   localparam logic [2:0] OP_XOR  = 3'b100;
   localparam logic [2:0] OP_NAND = 3'b101;
   localparam logic [2:0] OP_MOD  = 3'b110;
   localparam logic [2:0] OP_NEG  = 3'b111;
   localparam logic [7:0] DIVZ_RESULT = 8'hFF;
   typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;
endpackage

// File: rtl/alu_share_alu.sv
// alu_share_alu: combinational ALU, operands zero-extended to the result width; traps div/mod by zero.
module alu_share_alu
   import alu_share_pkg::*;
#(
   parameter int DW  = 4,
   parameter int OPW = 3,
   parameter int RW  = 8
) (
   input  logic [DW-1:0]  a,
   input  logic [DW-1:0]  b,
   input  logic [OPW-1:0] op,
   output logic [RW-1:0]  y,
   output logic           err
);
   logic [RW-1:0] ea, eb;
   assign ea  = RW'(a);
   assign eb  = RW'(b);
   assign err = (op == OP_DIV || op == OP_MOD) && b == '0;
   always_comb begin
      y = '0;
      case (op)
         OP_ADD:  y = ea + eb;
         OP_SUB:  y = ea - eb;
         OP_MUL:  y = ea * eb;
         OP_DIV:  y = err ? RW'(DIVZ_RESULT) : ea / eb;
         OP_XOR:  y = ea ^ eb;
         OP_NAND: y = ~(ea & eb);
         OP_MOD:  y = err ? RW'(DIVZ_RESULT) : ea % eb;
         OP_NEG:  y = '0 - ea;
         default: y = '0;
      endcase
   end
endmodule

// File: rtl/alu_share_ctrl_rr_arb.sv
// rr_arb: combinational round-robin picker; first set request at or after ptr, cyclically.
module rr_arb #(
   parameter int NREQ = 2,
   parameter int IW   = NREQ > 1 ? $clog2(NREQ) : 1
) (
   input  logic [NREQ-1:0] req,
   input  logic [IW-1:0]   ptr,
   output logic [NREQ-1:0] gnt,
   output logic [IW-1:0]   idx
);
   // Scanning from the farthest position back lets the nearest valid one win.
   always_comb begin
      idx = '0;
      for (int i = NREQ - 1; i >= 0; i--)
         if (req[(int'(ptr) + i) % NREQ]) idx = IW'((int'(ptr) + i) % NREQ);
   end
   assign gnt = (|req) ? NREQ'(1) << idx : '0;
endmodule

// File: rtl/alu_share_ctrl.sv
// alu_share_ctrl: round-robin sharing of one combinational ALU among NREQ requesters,
// one command in flight, registered result returned over a valid/ready handshake.
module alu_share_ctrl
   import alu_share_pkg::*;
#(
   parameter int NREQ = 2,
   parameter int DW   = 4,
   parameter int OPW  = 3,
   parameter int RW   = 8,
   parameter int IW   = NREQ > 1 ? $clog2(NREQ) : 1
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic [NREQ-1:0]   req_valid,
   output logic [NREQ-1:0]   req_ready,
   input  logic [NREQ*DW-1:0]  req_a,
   input  logic [NREQ*DW-1:0]  req_b,
   input  logic [NREQ*OPW-1:0] req_op,
   output logic [NREQ-1:0]   rsp_valid,
   input  logic [NREQ-1:0]   rsp_ready,
   output logic [RW-1:0]     rsp_data,
   output logic              rsp_err,
   output logic              busy,
   output logic [IW-1:0]     grant_id
);
   state_t         state;
   logic [IW-1:0]  ptr, idx;
   logic [NREQ-1:0] gnt;
   logic [DW-1:0]  a_q, b_q;
   logic [OPW-1:0] op_q;
   logic [RW-1:0]  alu_y;
   logic           alu_err;
   rr_arb #(.NREQ(NREQ), .IW(IW)) u_arb (
      .req(req_valid), .ptr(ptr), .gnt(gnt), .idx(idx)
   );
   alu_share_alu #(.DW(DW), .OPW(OPW), .RW(RW)) u_alu (
      .a(a_q), .b(b_q), .op(op_q), .y(alu_y), .err(alu_err)
   );
   assign req_ready = state == IDLE ? gnt : '0;
   assign rsp_valid = state == RESP ? NREQ'(1) << grant_id : '0;
   assign busy      = state != IDLE;
   // The pointer moves only when the owner takes its response, not at grant time.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state    <= IDLE;
         ptr      <= '0;
         grant_id <= '0;
         a_q      <= '0;
         b_q      <= '0;
         op_q     <= '0;
         rsp_data <= '0;
         rsp_err  <= 1'b0;
      end else begin
         case (state)
            IDLE: if (|req_valid) begin
               a_q      <= req_a[idx*DW +: DW];
               b_q      <= req_b[idx*DW +: DW];
               op_q     <= req_op[idx*OPW +: OPW];
               grant_id <= idx;
               state    <= EXEC;
            end
            EXEC: begin
               rsp_data <= alu_y;
               rsp_err  <= alu_err;
               state    <= RESP;
            end
            RESP: if (rsp_ready[grant_id]) begin
               ptr   <= grant_id == IW'(NREQ - 1) ? '0 : grant_id + IW'(1);
               state <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_alu_share_ctrl.sv
// tb_alu_share_ctrl: directed and randomized commands checked against an arithmetic reference
// and a round-robin ownership model.
module tb_alu_share_ctrl;
   localparam int NREQ = 2;
   logic       clk = 0, rst_n = 0;
   logic [1:0] req_valid = 0, rsp_ready = 0, req_ready, rsp_valid;
   logic [7:0] req_a = 0, req_b = 0, rsp_data;
   logic [5:0] req_op = 0;
   logic       rsp_err, busy;
   logic [0:0] grant_id;
   int         checks = 0, failures = 0, ptr_m = 0, g;
   logic [7:0] d;
   logic       e;

   alu_share_ctrl #(.NREQ(NREQ), .DW(4), .OPW(3), .RW(8)) dut (
      .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready),
      .req_a(req_a), .req_b(req_b), .req_op(req_op), .rsp_valid(rsp_valid),
      .rsp_ready(rsp_ready), .rsp_data(rsp_data), .rsp_err(rsp_err), .busy(busy),
      .grant_id(grant_id)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // {err, data} from the opcode table using plain integer arithmetic
   function automatic logic [8:0] ref_alu(input int a, input int b, input int op);
      int r;
      case (op)
         0: r = a + b;
         1: r = (a - b + 256) % 256;
         2: r = a * b;
         3: r = b == 0 ? 255 : a / b;
         4: r = a ^ b;
         5: r = 255 - (a & b);
         6: r = b == 0 ? 255 : a % b;
         default: r = (256 - a) % 256;
      endcase
      return {(op == 3 || op == 6) && b == 0, 8'(r)};
   endfunction

   task automatic set_cmd(input int k, input int a, input int b, input int op);
      req_a[k*4 +: 4]  = 4'(a);
      req_b[k*4 +: 4]  = 4'(b);
      req_op[k*3 +: 3] = 3'(op);
      req_valid[k]     = 1'b1;
   endtask

   task automatic chk_reset_outputs();
      chk("rst_req_ready", req_ready, 0);
      chk("rst_rsp_valid", rsp_valid, 0);
      chk("rst_rsp_data", rsp_data, 0);
      chk("rst_rsp_err", rsp_err, 0);
      chk("rst_busy", busy, 0);
      chk("rst_grant_id", grant_id, 0);
   endtask

   // Runs one full command from an IDLE cycle with at least one valid request.
   task automatic serve(input int delay, input logic [1:0] raise, output int gs,
                        output logic [7:0] ds, output logic es);
      logic [8:0] x;
      #1;
      gs = -1;
      for (int i = 0; i < NREQ; i++)
         if (gs < 0 && req_valid[(ptr_m + i) % NREQ]) gs = (ptr_m + i) % NREQ;
      ds = 0;
      es = 0;
      if (gs < 0) begin
         chk("no_valid_request", 32'(req_valid), 1);
         return;
      end
      x = ref_alu(int'(req_a[gs*4 +: 4]), int'(req_b[gs*4 +: 4]), int'(req_op[gs*3 +: 3]));
      chk("grant_ready", req_ready, 1 << gs);
      chk("idle_busy", busy, 0);
      @(posedge clk); #2;
      req_valid |= raise;
      chk("exec_busy", busy, 1);
      chk("exec_ready", req_ready, 0);
      chk("exec_rsp_valid", rsp_valid, 0);
      chk("grant_id", grant_id, gs);
      @(posedge clk); #2;
      ds = rsp_data;
      es = rsp_err;
      chk("rsp_valid", rsp_valid, 1 << gs);
      chk("rsp_data", rsp_data, x[7:0]);
      chk("rsp_err", rsp_err, x[8]);
      chk("resp_ready", req_ready, 0);
      rsp_ready = 2'b11 ^ 2'(1 << gs);
      repeat (delay) begin
         @(posedge clk); #2;
         chk("stall_valid", rsp_valid, 1 << gs);
         chk("stall_data", rsp_data, x[7:0]);
         chk("stall_err", rsp_err, x[8]);
         chk("stall_ready", req_ready, 0);
      end
      rsp_ready = 2'(1 << gs);
      @(posedge clk); #2;
      rsp_ready = 0;
      chk("done_valid", rsp_valid, 0);
      chk("done_busy", busy, 0);
      ptr_m = (gs + 1) % NREQ;
   endtask

   initial begin
      repeat (2) @(posedge clk);
      #2;
      chk_reset_outputs();
      rst_n = 1;
      set_cmd(0, 9, 3, 2);
      serve(0, 0, g, d, e);
      req_valid = 0;
      chk("mul_owner", g, 0);
      chk("mul_data", d, 8'h1B);
      chk("mul_err", e, 0);
      set_cmd(0, 1, 1, 0);
      set_cmd(1, 1, 1, 0);
      for (int n = 0; n < 4; n++) begin
         serve(0, 0, g, d, e);
         chk("alt_owner", g, (n + 1) % 2);
         chk("alt_data", d, 8'h02);
      end
      req_valid = 0;
      set_cmd(1, 7, 0, 3);
      serve(0, 0, g, d, e);
      req_valid = 0;
      chk("divz_data", d, 8'hFF);
      chk("divz_err", e, 1);
      set_cmd(1, 13, 4, 6);
      serve(0, 0, g, d, e);
      req_valid = 0;
      chk("mod_data", d, 8'h01);
      chk("mod_err", e, 0);
      set_cmd(1, 2, 2, 2);
      set_cmd(0, 5, 6, 0);
      req_valid[0] = 0;
      serve(5, 2'b01, g, d, e);
      req_valid[1] = 0;
      chk("stall_owner", g, 1);
      serve(0, 0, g, d, e);
      req_valid = 0;
      chk("after_stall_owner", g, 0);
      chk("after_stall_data", d, 8'h0B);
      set_cmd(0, 3, 5, 1);
      serve(0, 0, g, d, e);
      req_valid = 0;
      chk("sub_data", d, 8'hFE);
      set_cmd(0, 15, 15, 5);
      serve(0, 0, g, d, e);
      req_valid = 0;
      chk("nand_data", d, 8'hF0);
      set_cmd(0, 3, 9, 7);
      serve(0, 0, g, d, e);
      req_valid = 0;
      chk("neg3_data", d, 8'hFD);
      set_cmd(0, 0, 4, 7);
      serve(0, 0, g, d, e);
      req_valid = 0;
      chk("neg0_data", d, 8'h00);
      for (int k = 0; k < NREQ; k++)
         set_cmd(k, $urandom_range(15, 0), $urandom_range(15, 0), $urandom_range(7, 0));
      for (int n = 0; n < 40; n++) begin
         if (req_valid == 0) req_valid[$urandom_range(1, 0)] = 1'b1;
         serve($urandom_range(2, 0), 0, g, d, e);
         for (int k = 0; k < NREQ; k++)
            if (k == g || !req_valid[k]) begin
               set_cmd(k, $urandom_range(15, 0), $urandom_range(15, 0), $urandom_range(7, 0));
               req_valid[k] = 1'($urandom_range(1, 0));
            end else if ($urandom_range(3, 0) == 0) req_valid[k] = 1'b0;
      end
      req_valid = 0;
      set_cmd(0, 12, 5, 2);
      serve(0, 0, g, d, e);
      chk("pre_reset_data", d, 8'h3C);
      set_cmd(0, 2, 3, 2);
      #1;
      chk("pre_reset_grant", req_ready, 2'b01);
      @(posedge clk); #2;
      chk("pre_reset_busy", busy, 1);
      req_valid = 0;
      rst_n = 0;
      #1;
      chk_reset_outputs();
      ptr_m = 0;
      @(posedge clk); #2;
      rst_n = 1;
      repeat (2) begin
         @(posedge clk); #2;
         chk("post_reset_rsp_valid", rsp_valid, 0);
         chk("post_reset_busy", busy, 0);
      end
      set_cmd(0, 1, 2, 0);
      set_cmd(1, 3, 4, 0);
      serve(0, 0, g, d, e);
      req_valid = 0;
      chk("post_reset_owner", g, 0);
      chk("post_reset_data", d, 8'h03);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
